// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 4-digit multiplexed seven-segment display path.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    // Active-low, one-cold anode pattern selecting a single digit.
    function automatic logic [NUM_DIGITS-1:0] anode_for(digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Valid/ready value-load channel feeding the display scanner.
interface seg_scan_mux_if;
    import seg_pkg::*;

    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    value_valid;
    logic                    value_ready;

    modport master (output value_in, output dp_in, output value_valid, input value_ready);
    modport slave  (input value_in, input dp_in, input value_valid, output value_ready);

endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks.
module seg_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q;

    assign tick = (count_q == CntMax);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Scans a 16-bit hex value across four digits; new values land only at frame boundaries,
// with per-slot dead time and optional leading-zero blanking.
module seg_scan_mux
    import seg_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_mux_if.slave         in_if,
    input  logic                  blank_lz,
    output logic [3:0]            digit_data,
    output logic                  digit_blank,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] Anode_Activate,
    output logic                  frame_done
);

    logic tick;
    logic boundary;
    logic transfer;

    digit_idx_t              idx_q;
    logic                    slot_start_q;
    logic [4*NUM_DIGITS-1:0] pending_q;
    logic [4*NUM_DIGITS-1:0] display_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    logic                    pending_full_q;

    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  slot_dark;
    logic [3:0]            data_d;
    logic                  blank_d;
    logic                  dpn_d;
    logic [NUM_DIGITS-1:0] anode_d;

    seg_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign boundary          = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    assign in_if.value_ready = ~pending_full_q;
    assign transfer          = in_if.value_valid && ~pending_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q      <= '0;
            pend_dp_q      <= '0;
            pending_full_q <= 1'b0;
            display_q      <= '0;
            dp_q           <= '0;
        end else if (boundary && pending_full_q) begin
            display_q      <= pending_q;
            dp_q           <= pend_dp_q;
            pending_full_q <= 1'b0;
        end else if (boundary && transfer) begin
            // Arrived exactly on the boundary: skip the pending stage entirely.
            display_q <= in_if.value_in;
            dp_q      <= in_if.dp_in;
        end else if (transfer) begin
            pending_q      <= in_if.value_in;
            pend_dp_q      <= in_if.dp_in;
            pending_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q        <= '0;
            slot_start_q <= 1'b1;
        end else begin
            slot_start_q <= tick;
            if (tick) begin
                idx_q <= idx_q + digit_idx_t'(1);
            end
        end
    end

    always_comb begin
        lead_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lead_zero[i] = (display_q >> (4 * i)) == '0;
        end
        // Slot 0 always lights so an all-zero value still reads "0".
        slot_dark = blank_lz && (idx_q != '0) && lead_zero[idx_q];
        data_d    = display_q[{idx_q, 2'b00} +: 4];
        blank_d   = slot_dark;
        dpn_d     = slot_dark | ~dp_q[idx_q];
        anode_d   = (slot_dark || slot_start_q) ? ANODE_OFF : anode_for(idx_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Anode_Activate <= ANODE_OFF;
            digit_data     <= '0;
            digit_blank    <= 1'b1;
            dp_n           <= 1'b1;
            frame_done     <= 1'b0;
        end else begin
            Anode_Activate <= anode_d;
            digit_data     <= data_d;
            digit_blank    <= blank_d;
            dp_n           <= dpn_d;
            frame_done     <= boundary;
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench: expected display frames are queued by the stimulus and checked by a monitor.
module tb_seg_scan_mux;
    import seg_pkg::*;

    localparam int unsigned TickDiv     = 4;
    localparam int unsigned FrameCycles = TickDiv * NUM_DIGITS;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       blank_lz = 1'b0;
    logic [3:0] digit_data;
    logic       digit_blank;
    logic       dp_n;
    logic [3:0] Anode_Activate;
    logic       frame_done;

    seg_scan_mux_if bus ();

    seg_scan_mux #(
        .TICK_DIV(TickDiv)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_if         (bus),
        .blank_lz      (blank_lz),
        .digit_data    (digit_data),
        .digit_blank   (digit_blank),
        .dp_n          (dp_n),
        .Anode_Activate(Anode_Activate),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    // Per slot: {anode[3:0], data[3:0], blank, dp_n}; slot 0 in the low 10 bits.
    typedef struct {
        int          id;
        logic [39:0] slots;
    } frame_t;

    frame_t exp_q[$];
    int     checks   = 0;
    int     errors   = 0;
    bit     mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] sl(input logic [3:0] an, input logic [3:0] d,
                                      input logic b, input logic dpn);
        return {an, d, b, dpn};
    endfunction

    task automatic push_frame(input int id, input logic [9:0] s0, input logic [9:0] s1,
                              input logic [9:0] s2, input logic [9:0] s3);
        frame_t f;
        f.id    = id;
        f.slots = {s3, s2, s1, s0};
        exp_q.push_back(f);
    endtask

    // Monitor: a frame starts on the sample after frame_done and spans FrameCycles samples.
    initial begin : monitor
        frame_t      cur;
        int          k;
        logic [9:0]  e;
        logic [3:0]  an_e;
        logic [10:0] ev;
        logic [10:0] av;
        k = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_busy = 1'b0;
            end else if (mon_busy) begin
                e    = cur.slots[10*(k/TickDiv) +: 10];
                an_e = ((k % TickDiv) == 0) ? 4'b1111 : e[9:6];
                ev   = {an_e, e[5:2], e[1], e[0], (k == FrameCycles - 1)};
                av   = {Anode_Activate, digit_data, digit_blank, dp_n, frame_done};
                check($sformatf("frame%0d sample%0d {an,data,blank,dpn,fd}", cur.id, k),
                      32'(av), 32'(ev));
                k++;
                if (k == FrameCycles) mon_busy = 1'b0;
            end
            if (!mon_busy && !reset && frame_done && exp_q.size() > 0) begin
                cur      = exp_q.pop_front();
                mon_busy = 1'b1;
                k        = 0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_boundary(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!frame_done && n < 2 * FrameCycles);
        check({name, " frame_done seen"}, 32'(frame_done), 32'd1);
    endtask

    task automatic send(input logic [15:0] v, input logic [3:0] dp);
        bus.value_in    = v;
        bus.dp_in       = dp;
        bus.value_valid = 1'b1;
        cyc(1);
        bus.value_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " anode"}, 32'(Anode_Activate), 32'hF);
        check({tag, " digit_data"}, 32'(digit_data), 32'h0);
        check({tag, " digit_blank"}, 32'(digit_blank), 32'd1);
        check({tag, " dp_n"}, 32'(dp_n), 32'd1);
        check({tag, " value_ready"}, 32'(bus.value_ready), 32'd1);
        check({tag, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin : stim
        bus.value_in    = '0;
        bus.dp_in       = '0;
        bus.value_valid = 1'b0;

        #23;
        check_reset_outputs("initial reset");
        @(posedge clk);
        #3 reset = 1'b0;

        // 1234 with dp on digit 2, no blanking
        cyc(2);
        check("ready idle", 32'(bus.value_ready), 32'd1);
        send(16'h1234, 4'b0100);
        check("ready after 1234", 32'(bus.value_ready), 32'd0);
        wait_boundary("b1");
        push_frame(1, sl(4'b1110, 4'h4, 0, 1), sl(4'b1101, 4'h3, 0, 1),
                      sl(4'b1011, 4'h2, 0, 0), sl(4'b0111, 4'h1, 0, 1));
        check("ready after apply 1234", 32'(bus.value_ready), 32'd1);

        // 0050 with leading-zero blanking; dark slots keep dp off
        cyc(3);
        blank_lz = 1'b1;
        send(16'h0050, 4'b1100);
        wait_boundary("b2");
        push_frame(2, sl(4'b1110, 4'h0, 0, 1), sl(4'b1101, 4'h5, 0, 1),
                      sl(4'b1111, 4'h0, 1, 1), sl(4'b1111, 4'h0, 1, 1));
        wait_boundary("b3");
        blank_lz = 1'b0;
        push_frame(3, sl(4'b1110, 4'h0, 0, 1), sl(4'b1101, 4'h5, 0, 1),
                      sl(4'b1011, 4'h0, 0, 0), sl(4'b0111, 4'h0, 0, 0));

        // Back-to-back: BBBB held off while AAAA is pending
        cyc(3);
        send(16'hAAAA, 4'b0001);
        bus.value_in    = 16'hBBBB;
        bus.dp_in       = 4'b1000;
        bus.value_valid = 1'b1;
        cyc(2);
        check("ready held off", 32'(bus.value_ready), 32'd0);
        wait_boundary("b4");
        push_frame(4, sl(4'b1110, 4'hA, 0, 0), sl(4'b1101, 4'hA, 0, 1),
                      sl(4'b1011, 4'hA, 0, 1), sl(4'b0111, 4'hA, 0, 1));
        check("ready after AAAA apply", 32'(bus.value_ready), 32'd1);
        cyc(1);
        bus.value_valid = 1'b0;
        check("ready after BBBB taken", 32'(bus.value_ready), 32'd0);
        wait_boundary("b5");
        push_frame(5, sl(4'b1110, 4'hB, 0, 1), sl(4'b1101, 4'hB, 0, 1),
                      sl(4'b1011, 4'hB, 0, 1), sl(4'b0111, 4'hB, 0, 0));

        // Transfer coincident with the boundary tick goes straight to the display
        cyc(FrameCycles - 1);
        bus.value_in    = 16'hC0DE;
        bus.dp_in       = 4'b0010;
        bus.value_valid = 1'b1;
        cyc(1);
        bus.value_valid = 1'b0;
        check("coincident frame_done", 32'(frame_done), 32'd1);
        check("coincident ready", 32'(bus.value_ready), 32'd1);
        push_frame(6, sl(4'b1110, 4'hE, 0, 1), sl(4'b1101, 4'hD, 0, 0),
                      sl(4'b1011, 4'h0, 0, 1), sl(4'b0111, 4'hC, 0, 1));

        // Reset while a value is pending drops it
        wait_boundary("b7");
        cyc(3);
        send(16'h7777, 4'b1111);
        check("ready with 7777 pending", 32'(bus.value_ready), 32'd0);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("mid-frame reset");
        cyc(2);
        #2 reset = 1'b0;
        check("ready after reset release", 32'(bus.value_ready), 32'd1);
        wait_boundary("b8");
        push_frame(7, sl(4'b1110, 4'h0, 0, 1), sl(4'b1101, 4'h0, 0, 1),
                      sl(4'b1011, 4'h0, 0, 1), sl(4'b0111, 4'h0, 0, 1));
        check("ready after post-reset boundary", 32'(bus.value_ready), 32'd1);
        wait_boundary("b9");
        cyc(1);
        check("scoreboard drained", 32'(exp_q.size()) + 32'(mon_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
